// File: rtl/mem_stage_pipe_if.sv
// Bundle of upstream (EX/MEM), data-memory and downstream (MEM/WB) signals
// around the memory stage; the stage sits on the slave side.
interface mem_stage_pipe_if #(
   parameter int ADDR_W = 32,
   parameter int REG_W  = 5
) ();
   // upstream
   logic              in_valid;
   logic              in_ready;
   logic [ADDR_W-1:0] target;
   logic              equal;
   logic              branch;
   logic [31:0]       alu_res;
   logic [31:0]       val2;
   logic [REG_W-1:0]  des;
   logic              mem_read;
   logic              mem_write;
   logic [1:0]        size;
   logic              load_unsigned;
   logic              write_back;
   // data memory
   logic              dm_req;
   logic              dm_we;
   logic [ADDR_W-1:0] dm_addr;
   logic [31:0]       dm_wdata;
   logic [3:0]        dm_be;
   logic              dm_ack;
   logic [31:0]       dm_rdata;
   // downstream
   logic              pc_src;
   logic [ADDR_W-1:0] target_address;
   logic              wb_valid;
   logic              wb_write_back;
   logic [REG_W-1:0]  wb_des;
   logic [31:0]       wb_alu_res;
   logic [31:0]       wb_mem_data;
   logic              wb_mem_to_reg;
   logic              stall;
   logic              err;

   modport slave (
      input  in_valid, target, equal, branch, alu_res, val2, des, mem_read,
             mem_write, size, load_unsigned, write_back, dm_ack, dm_rdata,
      output in_ready, dm_req, dm_we, dm_addr, dm_wdata, dm_be, pc_src,
             target_address, wb_valid, wb_write_back, wb_des, wb_alu_res,
             wb_mem_data, wb_mem_to_reg, stall, err
   );

   modport master (
      output in_valid, target, equal, branch, alu_res, val2, des, mem_read,
             mem_write, size, load_unsigned, write_back, dm_ack, dm_rdata,
      input  in_ready, dm_req, dm_we, dm_addr, dm_wdata, dm_be, pc_src,
             target_address, wb_valid, wb_write_back, wb_des, wb_alu_res,
             wb_mem_data, wb_mem_to_reg, stall, err
   );
endinterface

// File: rtl/mem_stage_pipe.sv
// Pipeline MEM stage: accepts one EX/MEM bundle at a time, runs at most one
// data-memory transaction with timeout, and emits a one-cycle MEM/WB bundle.
module mem_stage_pipe #(
   parameter int ADDR_W  = 32,
   parameter int REG_W   = 5,
   parameter int TIMEOUT = 15
) (
   input  logic            clk,
   input  logic            rst,
   mem_stage_pipe_if.slave bus
);

   typedef enum logic {IDLE, BUSY} state_e;

   state_e            state_q;
   logic [7:0]        cnt_q;
   logic [1:0]        off_q;
   logic [1:0]        size_q;
   logic              unsigned_q;

   logic              dm_req_q, dm_we_q;
   logic [ADDR_W-1:0] dm_addr_q;
   logic [31:0]       dm_wdata_q;
   logic [3:0]        dm_be_q;
   logic              pc_src_q;
   logic [ADDR_W-1:0] target_q;
   logic              wb_valid_q, wb_write_back_q, wb_mem_to_reg_q, err_q;
   logic [REG_W-1:0]  wb_des_q;
   logic [31:0]       wb_alu_res_q, wb_mem_data_q;

   logic              accept;
   logic              is_mem;
   logic              misalign;
   logic [1:0]        off;
   logic [ADDR_W-1:0] addr_full;
   logic [ADDR_W-1:0] dm_addr_d;
   logic [3:0]        dm_be_d;
   logic [31:0]       dm_wdata_d;

   assign accept    = bus.in_valid && (state_q == IDLE);
   assign is_mem    = bus.mem_read || bus.mem_write;
   assign off       = bus.alu_res[1:0];
   assign misalign  = is_mem && (((bus.size == 2'b01) && off[0]) ||
                                 (bus.size[1] && (off != 2'b00)));
   assign addr_full = ADDR_W'(bus.alu_res);
   assign dm_addr_d = {addr_full[ADDR_W-1:2], 2'b00};

   // NOTE: every variable written here gets a default first so no latch is inferred.
   always_comb begin
      dm_be_d    = 4'b1111;
      dm_wdata_d = bus.val2;
      case (bus.size)
         2'b00: begin
            dm_be_d    = 4'b0001 << off;
            dm_wdata_d = {4{bus.val2[7:0]}};
         end
         2'b01: begin
            dm_be_d    = off[1] ? 4'b1100 : 4'b0011;
            dm_wdata_d = {2{bus.val2[15:0]}};
         end
         default: ;
      endcase
   end

   // Little-endian lane extraction with sign or zero extension.
   function automatic logic [31:0] load_align(input logic [31:0] rdata,
                                              input logic [1:0]  lane,
                                              input logic [1:0]  sz,
                                              input logic        uns);
      logic [31:0] sh;
      sh = rdata >> {lane, 3'b000};
      case (sz)
         2'b00:   return uns ? {24'b0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
         2'b01:   return uns ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
         default: return rdata;
      endcase
   endfunction

   // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= IDLE;
         cnt_q           <= '0;
         off_q           <= '0;
         size_q          <= '0;
         unsigned_q      <= 1'b0;
         dm_req_q        <= 1'b0;
         dm_we_q         <= 1'b0;
         dm_addr_q       <= '0;
         dm_wdata_q      <= '0;
         dm_be_q         <= '0;
         pc_src_q        <= 1'b0;
         target_q        <= '0;
         wb_valid_q      <= 1'b0;
         wb_write_back_q <= 1'b0;
         wb_mem_to_reg_q <= 1'b0;
         err_q           <= 1'b0;
         wb_des_q        <= '0;
         wb_alu_res_q    <= '0;
         wb_mem_data_q   <= '0;
      end else begin
         wb_valid_q <= 1'b0;
         pc_src_q   <= 1'b0;
         err_q      <= 1'b0;
         case (state_q)
            IDLE: if (accept) begin
               target_q        <= bus.target;
               pc_src_q        <= bus.branch && bus.equal;
               wb_des_q        <= bus.des;
               wb_alu_res_q    <= bus.alu_res;
               wb_mem_to_reg_q <= bus.mem_read && !bus.mem_write;
               off_q           <= off;
               size_q          <= bus.size;
               unsigned_q      <= bus.load_unsigned;
               if (!is_mem) begin
                  wb_valid_q      <= 1'b1;
                  wb_write_back_q <= bus.write_back;
               end else if (misalign) begin
                  wb_valid_q      <= 1'b1;
                  wb_write_back_q <= 1'b0;
                  err_q           <= 1'b1;
               end else begin
                  state_q         <= BUSY;
                  cnt_q           <= '0;
                  dm_req_q        <= 1'b1;
                  dm_we_q         <= bus.mem_write;
                  dm_addr_q       <= dm_addr_d;
                  dm_wdata_q      <= dm_wdata_d;
                  dm_be_q         <= dm_be_d;
                  wb_write_back_q <= bus.write_back;
               end
            end
            BUSY: begin
               // ack wins over a timeout landing on the same edge
               if (bus.dm_ack) begin
                  state_q       <= IDLE;
                  dm_req_q      <= 1'b0;
                  wb_valid_q    <= 1'b1;
                  wb_mem_data_q <= load_align(bus.dm_rdata, off_q, size_q, unsigned_q);
               end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                  state_q         <= IDLE;
                  dm_req_q        <= 1'b0;
                  wb_valid_q      <= 1'b1;
                  wb_write_back_q <= 1'b0;
                  err_q           <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.in_ready       = (state_q == IDLE);
   assign bus.stall          = (state_q != IDLE);
   assign bus.dm_req         = dm_req_q;
   assign bus.dm_we          = dm_we_q;
   assign bus.dm_addr        = dm_addr_q;
   assign bus.dm_wdata       = dm_wdata_q;
   assign bus.dm_be          = dm_be_q;
   assign bus.pc_src         = pc_src_q;
   assign bus.target_address = target_q;
   assign bus.wb_valid       = wb_valid_q;
   assign bus.wb_write_back  = wb_write_back_q;
   assign bus.wb_des         = wb_des_q;
   assign bus.wb_alu_res     = wb_alu_res_q;
   assign bus.wb_mem_data    = wb_mem_data_q;
   assign bus.wb_mem_to_reg  = wb_mem_to_reg_q;
   assign bus.err            = err_q;

endmodule

// File: tb/tb_mem_stage_pipe.sv
// Directed and randomized checks of mem_stage_pipe against an arithmetic
// reference model of the memory-stage rules.
module tb_mem_stage_pipe;

   localparam int ADDR_W  = 32;
   localparam int REG_W   = 5;
   localparam int TIMEOUT = 15;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fails  = 0;

   always #5 clk = ~clk;

   mem_stage_pipe_if #(.ADDR_W(ADDR_W), .REG_W(REG_W)) bus ();

   mem_stage_pipe #(.ADDR_W(ADDR_W), .REG_W(REG_W), .TIMEOUT(TIMEOUT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.in_valid = 0; bus.target = '0; bus.equal = 0; bus.branch = 0;
      bus.alu_res = '0; bus.val2 = '0; bus.des = '0; bus.mem_read = 0;
      bus.mem_write = 0; bus.size = 2'b10; bus.load_unsigned = 0;
      bus.write_back = 0; bus.dm_ack = 0; bus.dm_rdata = '0;
   endtask

   // Presents the bundle for one edge; outputs after that edge are visible on return.
   task automatic issue();
      bus.in_valid = 1;
      step();
      bus.in_valid = 0;
   endtask

   // Reference model: access width in bytes and lane arithmetic.
   function automatic int nbytes(input logic [1:0] sz);
      return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
   endfunction

   function automatic bit model_misaligned(input logic [31:0] addr, input logic [1:0] sz);
      return (addr % nbytes(sz)) != 0;
   endfunction

   function automatic logic [3:0] model_be(input logic [31:0] addr, input logic [1:0] sz);
      int nb   = nbytes(sz);
      int lane = ((addr % 4) / nb) * nb;
      return 4'(((1 << nb) - 1) << lane);
   endfunction

   function automatic logic [31:0] model_wdata(input logic [31:0] v, input logic [1:0] sz);
      int     nb  = nbytes(sz);
      longint pat = longint'(v) % (longint'(1) << (8 * nb));
      longint r   = 0;
      for (int k = 0; k < 4 / nb; k++) r += pat << (8 * nb * k);
      return 32'(r);
   endfunction

   function automatic logic [31:0] model_load(input logic [31:0] rd, input logic [31:0] addr,
                                              input logic [1:0] sz, input bit uns);
      int     nb   = nbytes(sz);
      longint span = longint'(1) << (8 * nb);
      longint v    = (longint'(rd) >> (8 * (addr % 4))) % span;
      if (!uns && v >= span / 2) v -= span;
      return 32'(v);
   endfunction

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          cycles;
      logic [31:0] addr, rd, v2;
      logic [1:0]  sz;
      bit          rdq, wrq, uns, wbq, brq, eqq;
      int          dly;

      clear_inputs();
      rst = 1;
      step(); step();
      rst = 0;

      check("reset_in_ready", bus.in_ready, 1);
      check("reset_stall", bus.stall, 0);
      check("reset_wb_valid", bus.wb_valid, 0);
      check("reset_dm_req", bus.dm_req, 0);
      check("reset_err", bus.err, 0);
      check("reset_target", bus.target_address, 0);

      // ALU op
      bus.alu_res = 32'h1234; bus.des = 7; bus.write_back = 1;
      issue();
      check("alu_wb_valid", bus.wb_valid, 1);
      check("alu_res", bus.wb_alu_res, 32'h1234);
      check("alu_des", bus.wb_des, 7);
      check("alu_write_back", bus.wb_write_back, 1);
      check("alu_mem_to_reg", bus.wb_mem_to_reg, 0);
      check("alu_no_req", bus.dm_req, 0);
      step();
      check("alu_wb_pulse_end", bus.wb_valid, 0);

      // taken branch, then not-taken branch
      clear_inputs();
      bus.branch = 1; bus.equal = 1; bus.target = 32'h40;
      issue();
      check("br_pc_src", bus.pc_src, 1);
      check("br_target", bus.target_address, 32'h40);
      step();
      check("br_pc_src_end", bus.pc_src, 0);
      check("br_target_hold", bus.target_address, 32'h40);
      bus.branch = 1; bus.equal = 0; bus.target = 32'h88;
      issue();
      check("br_nt_pc_src", bus.pc_src, 0);
      check("br_nt_target", bus.target_address, 32'h88);

      // signed byte load at 0x103, ack sampled after four request cycles
      clear_inputs();
      bus.alu_res = 32'h103; bus.mem_read = 1; bus.size = 2'b00;
      bus.write_back = 1; bus.des = 3;
      issue();
      check("lb_be", bus.dm_be, 4'b1000);
      check("lb_addr", bus.dm_addr, 32'h100);
      check("lb_we", bus.dm_we, 0);
      cycles = 0;
      for (int i = 0; i < 4; i++) begin
         if (bus.stall) cycles++;
         check("lb_req_held", bus.dm_req, 1);
         if (i == 3) begin bus.dm_ack = 1; bus.dm_rdata = 32'h80FFFFFF; end
         step();
      end
      bus.dm_ack = 0;
      check("lb_stall_cycles", cycles, 4);
      check("lb_wb_valid", bus.wb_valid, 1);
      check("lb_data", bus.wb_mem_data, 32'hFFFFFF80);
      check("lb_mem_to_reg", bus.wb_mem_to_reg, 1);
      check("lb_req_drop", bus.dm_req, 0);
      check("lb_stall_clear", bus.stall, 0);

      // stray ack while idle
      bus.dm_ack = 1;
      step();
      bus.dm_ack = 0;
      check("stray_ack_wb_valid", bus.wb_valid, 0);
      check("stray_ack_req", bus.dm_req, 0);

      // half store at 0x102
      clear_inputs();
      bus.alu_res = 32'h102; bus.mem_write = 1; bus.size = 2'b01; bus.val2 = 32'h1234ABCD;
      issue();
      check("sh_be", bus.dm_be, 4'b1100);
      check("sh_wdata", bus.dm_wdata, 32'hABCDABCD);
      check("sh_we", bus.dm_we, 1);
      bus.dm_ack = 1;
      step();
      bus.dm_ack = 0;
      check("sh_wb_valid", bus.wb_valid, 1);
      check("sh_mem_to_reg", bus.wb_mem_to_reg, 0);

      // read and write both set behave as a store
      clear_inputs();
      bus.alu_res = 32'h20; bus.mem_read = 1; bus.mem_write = 1; bus.val2 = 32'hCAFEF00D;
      issue();
      check("rw_we", bus.dm_we, 1);
      check("rw_wdata", bus.dm_wdata, 32'hCAFEF00D);
      bus.dm_ack = 1;
      step();
      bus.dm_ack = 0;
      check("rw_mem_to_reg", bus.wb_mem_to_reg, 0);

      // misaligned word load
      clear_inputs();
      bus.alu_res = 32'h101; bus.mem_read = 1; bus.write_back = 1;
      issue();
      check("mis_no_req", bus.dm_req, 0);
      check("mis_err", bus.err, 1);
      check("mis_wb_valid", bus.wb_valid, 1);
      check("mis_write_back", bus.wb_write_back, 0);
      step();
      check("mis_err_pulse_end", bus.err, 0);

      // timeout
      clear_inputs();
      bus.alu_res = 32'h200; bus.mem_read = 1; bus.write_back = 1;
      issue();
      cycles = 0;
      while (bus.dm_req && cycles < 40) begin
         cycles++;
         step();
      end
      check("to_req_cycles", cycles, TIMEOUT);
      check("to_err", bus.err, 1);
      check("to_wb_valid", bus.wb_valid, 1);
      check("to_write_back", bus.wb_write_back, 0);
      check("to_in_ready", bus.in_ready, 1);

      // reset while busy discards the bundle
      clear_inputs();
      bus.alu_res = 32'h300; bus.mem_read = 1; bus.write_back = 1;
      issue();
      step();
      rst = 1;
      step();
      rst = 0;
      check("rb_req_drop", bus.dm_req, 0);
      check("rb_in_ready", bus.in_ready, 1);
      bus.dm_ack = 1;
      cycles = 0;
      for (int i = 0; i < 3; i++) begin
         if (bus.wb_valid) cycles++;
         step();
      end
      bus.dm_ack = 0;
      check("rb_no_wb_valid", cycles, 0);

      // randomized bundles against the reference model
      for (int t = 0; t < 80; t++) begin
         clear_inputs();
         addr = $urandom; v2 = $urandom; rd = $urandom;
         sz   = 2'($urandom_range(0, 3));
         rdq  = 1'($urandom_range(0, 1)); wrq = 1'($urandom_range(0, 1));
         uns  = 1'($urandom_range(0, 1)); wbq = 1'($urandom_range(0, 1));
         brq  = 1'($urandom_range(0, 1)); eqq = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 3) == 0) addr = addr & ~32'h3;
         bus.alu_res = addr; bus.val2 = v2; bus.size = sz; bus.mem_read = rdq;
         bus.mem_write = wrq; bus.load_unsigned = uns; bus.write_back = wbq;
         bus.branch = brq; bus.equal = eqq; bus.target = ~addr;
         bus.des = 5'($urandom);
         issue();
         check("rnd_pc_src", bus.pc_src, 32'(brq && eqq));
         check("rnd_target", bus.target_address, ~addr);
         if (!rdq && !wrq) begin
            check("rnd_alu_valid", bus.wb_valid, 1);
            check("rnd_alu_wb", bus.wb_write_back, 32'(wbq));
            check("rnd_alu_res", bus.wb_alu_res, addr);
            check("rnd_alu_req", bus.dm_req, 0);
         end else if (model_misaligned(addr, sz)) begin
            check("rnd_mis_err", bus.err, 1);
            check("rnd_mis_valid", bus.wb_valid, 1);
            check("rnd_mis_wb", bus.wb_write_back, 0);
            check("rnd_mis_req", bus.dm_req, 0);
         end else begin
            check("rnd_addr", bus.dm_addr, addr & ~32'h3);
            check("rnd_be", bus.dm_be, model_be(addr, sz));
            check("rnd_we", bus.dm_we, 32'(wrq));
            if (wrq) check("rnd_wdata", bus.dm_wdata, model_wdata(v2, sz));
            dly = $urandom_range(0, 4);
            for (int i = 0; i <= dly; i++) begin
               check("rnd_req_held", bus.dm_req, 1);
               check("rnd_addr_held", bus.dm_addr, addr & ~32'h3);
               if (i == dly) begin bus.dm_ack = 1; bus.dm_rdata = rd; end
               step();
            end
            bus.dm_ack = 0;
            check("rnd_mem_valid", bus.wb_valid, 1);
            check("rnd_mem_err", bus.err, 0);
            check("rnd_mem_wb", bus.wb_write_back, 32'(wbq));
            check("rnd_mem_to_reg", bus.wb_mem_to_reg, 32'(rdq && !wrq));
            if (!wrq) check("rnd_load_data", bus.wb_mem_data, model_load(rd, addr, sz, uns));
         end
      end

      step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
